sync_ram_arbiter: RTL and testbench
===================================

Name: sync_ram_arbiter

Overview:
- Two-requester arbiter that shares one single-port synchronous RAM (N-bit words, M entries, one access per cycle, registered read data) between requester A (CPU data path) and requester B (loader/debug port).
- Round-robin arbitration with an optional bounded lock, so one requester can run an uninterrupted sequence such as read-modify-write.
- Sits between the requesters and the RAM. Drives the RAM address, write data and write enable, and routes read data back to the requester that issued the read.

Parameters:
N, 8, data word width
M, 32, number of RAM words; AddrSz = $clog2(M) is a derived localparam
MAX_LOCK, 8, maximum consecutive cycles a lock may be held before forced release (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
a_req  in  1  A requests an access this cycle
a_we  in  1  A access is a write (1) or read (0)
a_addr  in  AddrSz  A address
a_wdata  in  N  A write data
a_lock  in  1  A asks to keep ownership after this access
a_gnt  out  1  A access accepted this cycle (combinational)
a_rvalid  out  1  A read data valid
a_rdata  out  N  A read data
b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata: same as A, for B
ram_addr  out  AddrSz  to RAM addr
ram_w_data  out  N  to RAM w_data
ram_w_en  out  1  to RAM w_en
ram_r_data  in  N  from RAM r_data

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=FREE, ptr=A, lock_cnt=0, a_rvalid=b_rvalid=0, pend_rd=none.
- While rst=1: a_gnt=b_gnt=0 and ram_w_en=0.
- States: FREE, LOCK_A, LOCK_B.
- FREE arbitration:
  - Only one request present: that requester is granted.
  - Both requesting: the requester named by ptr is granted.
  - No request: no grant, ram_w_en=0, ram_addr=0.
- Grant routing: the granted requester's addr, wdata and we drive ram_addr, ram_w_data and ram_w_en in the same cycle. At most one grant per cycle.
- ptr update: after an unlocked grant to X, ptr becomes the other requester. It is unchanged when there is no grant.
- Entering lock: a grant to X with x_lock=1 moves FREE to LOCK_X and sets lock_cnt=1.
- In LOCK_X:
  - Only X may be granted, whenever x_req=1. The other requester gets gnt=0 even if X is idle.
  - lock_cnt increments every cycle.
  - Voluntary release: x_lock=0 at an edge moves to FREE and sets ptr=other. An access in that same cycle is still granted.
  - Forced release: an edge with lock_cnt==MAX_LOCK-1 moves to FREE, sets ptr=other and lock_cnt=0, whatever x_lock is.
  - After either release, X must win arbitration again before it can re-lock.
- Read latency:
  - The RAM samples addr/we at the edge that ends grant cycle k.
  - x_rvalid=1 in cycle k+1 only, with x_rdata = ram_r_data.
  - Back-to-back reads give rvalid on consecutive cycles.
- Writes produce no response. Write data is in RAM after the edge ending the grant cycle.
- Read after write to the same address in the next cycle returns the new data.
- x_rdata is don't-care when x_rvalid=0; implement it as a combinational pass-through of ram_r_data.
- Requester handshake: a requester holds req/we/addr/wdata stable until it sees gnt=1. Responses have no back-pressure; requesters must accept rvalid.
- Reset mid-operation: a pending read response is dropped (rvalid=0 in the cycle after reset). Lock state is discarded. RAM contents are not touched.
- Simultaneous write by the granted requester and read by the loser: only the write occurs. The loser retries, and its read in a later cycle returns the written data.

Test Plan:
- Reset then A writes 0xA5 to addr 3; next cycle A reads addr 3 -> a_gnt=1 both cycles; a_rvalid=1 one cycle after the read grant with a_rdata=0xA5; b_rvalid stays 0.
- A and B both request continuously (reads of addr 1 and 2) after reset -> grants alternate A,B,A,B; each rvalid is one cycle after its grant and carries its own addr's data.
- A locks: holds a_req=1, a_lock=1 for 3 cycles, then a_lock=0, while B requests throughout -> b_gnt=0 during the 4 A grants; B granted on the next cycle.
- A holds a_lock=1 and a_req=1 indefinitely, MAX_LOCK=8, B requesting -> A granted 8 cycles; B granted in cycle 9; then alternation resumes.
- Same-cycle conflict: A writes 0x3C to addr 5, B reads addr 5, ptr=A -> A granted; B granted next cycle; b_rdata=0x3C on b_rvalid.
- A read granted, rst=1 the following cycle -> a_rvalid=0 after the reset edge; gnt=0 and ram_w_en=0 while rst=1; ptr=A after release.

Source files
------------

// File: rtl/sync_ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous RAM.
// Requester A (CPU data path) and B (loader/debug) share one access per cycle.
// A grant may be extended into a bounded lock for uninterrupted sequences
// such as read-modify-write. Read data comes back one cycle after the grant.
module sync_ram_arbiter #(
    parameter int N        = 8,
    parameter int M        = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [$clog2(M)-1:0]   a_addr,
    input  logic [N-1:0]           a_wdata,
    input  logic                   a_lock,
    output logic                   a_gnt,
    output logic                   a_rvalid,
    output logic [N-1:0]           a_rdata,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [$clog2(M)-1:0]   b_addr,
    input  logic [N-1:0]           b_wdata,
    input  logic                   b_lock,
    output logic                   b_gnt,
    output logic                   b_rvalid,
    output logic [N-1:0]           b_rdata,
    output logic [$clog2(M)-1:0]   ram_addr,
    output logic [N-1:0]           ram_w_data,
    output logic                   ram_w_en,
    input  logic [N-1:0]           ram_r_data
);

    localparam int AddrSz = $clog2(M);
    localparam int CntW   = $clog2(MAX_LOCK + 1);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] LOCK_A = 2'd1;
    localparam logic [1:0] LOCK_B = 2'd2;

    // Last count value at which the lock is still held; the edge seen here
    // releases it, giving the owner exactly MAX_LOCK consecutive cycles.
    localparam logic [CntW-1:0] CNT_LAST = CntW'(MAX_LOCK - 1);

    logic [1:0]      state;
    logic            ptr;       // 0: A has priority on a tie, 1: B has priority
    logic [CntW-1:0] lock_cnt;

    // Grant decision: lock owner only, otherwise round-robin on contention.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            case (state)
                LOCK_A:  a_gnt = a_req;
                LOCK_B:  b_gnt = b_req;
                default: begin
                    if (a_req && (!b_req || !ptr)) begin
                        a_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Steer the granted requester onto the RAM port; idle port parks at zero.
    always_comb begin
        ram_addr   = '0;
        ram_w_data = '0;
        ram_w_en   = 1'b0;
        if (a_gnt) begin
            ram_addr   = a_addr;
            ram_w_data = a_wdata;
            ram_w_en   = a_we;
        end else if (b_gnt) begin
            ram_addr   = b_addr;
            ram_w_data = b_wdata;
            ram_w_en   = b_we;
        end
    end

    // Read data is shared; only the matching rvalid qualifies it.
    assign a_rdata = ram_r_data;
    assign b_rdata = ram_r_data;

    // Ownership state, round-robin pointer and lock duration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            ptr      <= 1'b0;
            lock_cnt <= '0;
        end else begin
            case (state)
                LOCK_A, LOCK_B: begin
                    if (lock_cnt == CNT_LAST ||
                        (state == LOCK_A ? !a_lock : !b_lock)) begin
                        state    <= FREE;
                        ptr      <= (state == LOCK_A);
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    if (a_gnt) begin
                        if (a_lock) begin
                            state    <= LOCK_A;
                            lock_cnt <= CntW'(1);
                        end else begin
                            ptr <= 1'b1;
                        end
                    end else if (b_gnt) begin
                        if (b_lock) begin
                            state    <= LOCK_B;
                            lock_cnt <= CntW'(1);
                        end else begin
                            ptr <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Remember which requester issued the read so its response is flagged
    // in the cycle the RAM presents the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
        end
    end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: behavioural RAM, ownership-level reference
// model, directed scenarios followed by randomized requester traffic.
module tb_sync_ram_arbiter;

    localparam int N        = 8;
    localparam int M        = 32;
    localparam int MAX_LOCK = 8;
    localparam int AW       = $clog2(M);

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_lock;
    logic [AW-1:0] a_addr;
    logic [N-1:0]  a_wdata;
    logic          b_req, b_we, b_lock;
    logic [AW-1:0] b_addr;
    logic [N-1:0]  b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [N-1:0]  a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [N-1:0]  ram_w_data;
    logic          ram_w_en;
    logic [N-1:0]  ram_r_data;

    int checks   = 0;
    int failures = 0;

    sync_ram_arbiter #(.N(N), .M(M), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_w_en(ram_w_en),
        .ram_r_data(ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    logic [N-1:0] ram_mem [M];
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_addr] <= ram_w_data;
        ram_r_data <= ram_mem[ram_addr];
    end

    // Reference model: who owns the RAM, whose turn it is on a tie, how many
    // cycles the current owner has held it, expected memory image and the
    // read response due next cycle.
    int           owner;      // 0 none, 1 A, 2 B
    int           turn;       // 1 A, 2 B
    int           held;
    logic [N-1:0] ref_mem [M];
    bit           exp_rv_a, exp_rv_b;
    logic [N-1:0] exp_rd_a, exp_rd_b;
    bit           g_a, g_b;
    int           na, nb;     // observed grant counters for directed checks

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input int addr,
                         input int wdata, input logic lock);
        a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = N'(wdata); a_lock = lock;
    endtask

    task automatic set_b(input logic req, input logic we, input int addr,
                         input int wdata, input logic lock);
        b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = N'(wdata); b_lock = lock;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [AW-1:0] e_addr;
        logic [N-1:0]  e_wdata;
        logic          e_wen;
        #1;
        g_a = 1'b0;
        g_b = 1'b0;
        if (!rst) begin
            if (owner == 1)      g_a = a_req;
            else if (owner == 2) g_b = b_req;
            else if (a_req && b_req) begin
                g_a = (turn == 1);
                g_b = (turn == 2);
            end else begin
                g_a = a_req;
                g_b = b_req;
            end
        end
        e_addr = g_a ? a_addr : (g_b ? b_addr : '0);
        e_wdata = g_a ? a_wdata : b_wdata;
        e_wen = g_a ? a_we : (g_b ? b_we : 1'b0);
        check("a_gnt", 32'(a_gnt), 32'(g_a));
        check("b_gnt", 32'(b_gnt), 32'(g_b));
        check("ram_w_en", 32'(ram_w_en), 32'(e_wen));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_wen) check("ram_w_data", 32'(ram_w_data), 32'(e_wdata));
        check("a_rvalid", 32'(a_rvalid), 32'(exp_rv_a));
        check("b_rvalid", 32'(b_rvalid), 32'(exp_rv_b));
        if (exp_rv_a) check("a_rdata", 32'(a_rdata), 32'(exp_rd_a));
        if (exp_rv_b) check("b_rdata", 32'(b_rdata), 32'(exp_rd_b));
        if (a_gnt) na++;
        if (b_gnt) nb++;
        @(posedge clk);
        if (rst) begin
            owner = 0; turn = 1; held = 0;
            exp_rv_a = 1'b0; exp_rv_b = 1'b0;
        end else begin
            exp_rv_a = g_a && !a_we;
            exp_rv_b = g_b && !b_we;
            exp_rd_a = ref_mem[a_addr];
            exp_rd_b = ref_mem[b_addr];
            if (g_a && a_we) ref_mem[a_addr] = a_wdata;
            if (g_b && b_we) ref_mem[b_addr] = b_wdata;
            if (owner == 0) begin
                if (g_a) begin
                    if (a_lock) begin owner = 1; held = 1; end
                    else turn = 2;
                end else if (g_b) begin
                    if (b_lock) begin owner = 2; held = 1; end
                    else turn = 1;
                end
            end else begin
                held++;
                if (held == MAX_LOCK || !(owner == 1 ? a_lock : b_lock)) begin
                    turn  = (owner == 1) ? 2 : 1;
                    owner = 0;
                    held  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    bit           pa, pb;
    logic         rwe_a, rwe_b;
    int           raddr_a, raddr_b, rwd_a, rwd_b;

    initial begin
        for (int i = 0; i < M; i++) begin
            ram_mem[i] = N'(i * 7 + 1);
            ref_mem[i] = N'(i * 7 + 1);
        end
        owner = 0; turn = 1; held = 0;
        exp_rv_a = 1'b0; exp_rv_b = 1'b0;
        exp_rd_a = '0; exp_rd_b = '0;
        rst = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Write then read back from A.
        set_a(1, 1, 3, 8'hA5, 0); cycle();
        set_a(1, 0, 3, 0, 0);     cycle();
        set_a(0, 0, 0, 0, 0);
        #1;
        check("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_a_rdata", 32'(a_rdata), 32'hA5);
        check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
        cycle();

        // Both reading continuously: strict alternation.
        do_reset();
        na = 0; nb = 0;
        set_a(1, 0, 1, 0, 0);
        set_b(1, 0, 2, 0, 0);
        for (int i = 0; i < 6; i++) cycle();
        check("t2_a_grants", 32'(na), 32'd3);
        check("t2_b_grants", 32'(nb), 32'd3);
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        cycle(); cycle();

        // Voluntary lock release after four A grants.
        do_reset();
        na = 0; nb = 0;
        set_b(1, 0, 4, 0, 0);
        set_a(1, 0, 6, 0, 1);
        for (int i = 0; i < 3; i++) cycle();
        set_a(1, 0, 6, 0, 0);
        cycle();
        check("t3_a_locked", 32'(na), 32'd4);
        check("t3_b_blocked", 32'(nb), 32'd0);
        set_a(0, 0, 0, 0, 0);
        cycle();
        check("t3_b_after", 32'(nb), 32'd1);
        set_b(0, 0, 0, 0, 0); cycle();

        // Forced release after MAX_LOCK cycles.
        do_reset();
        na = 0; nb = 0;
        set_a(1, 0, 7, 0, 1);
        set_b(1, 0, 8, 0, 0);
        for (int i = 0; i < MAX_LOCK; i++) cycle();
        check("t4_a_held", 32'(na), 32'(MAX_LOCK));
        check("t4_b_held_off", 32'(nb), 32'd0);
        cycle();
        check("t4_b_forced", 32'(nb), 32'd1);
        set_a(1, 0, 7, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        check("t4_alt_a", 32'(na), 32'(MAX_LOCK + 2));
        check("t4_alt_b", 32'(nb), 32'd3);
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); cycle(); cycle();

        // Write by winner, read by loser of the same address.
        do_reset();
        set_a(1, 1, 5, 8'h3C, 0);
        set_b(1, 0, 5, 0, 0);
        cycle();
        set_a(0, 0, 0, 0, 0);
        cycle();
        set_b(0, 0, 0, 0, 0);
        #1;
        check("t5_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t5_b_rdata", 32'(b_rdata), 32'h3C);
        cycle();

        // Reset with a read in flight.
        do_reset();
        set_b(1, 0, 2, 0, 0); cycle();     // B wins, ptr moves to A... then A read
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 9, 0, 1); cycle();
        rst = 1'b1;
        set_a(1, 1, 9, 8'h55, 1);
        set_b(1, 1, 9, 8'h66, 0);
        cycle();
        rst = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        #1;
        check("t6_a_rvalid_dropped", 32'(a_rvalid), 32'd0);
        cycle();
        set_a(1, 0, 9, 0, 0);
        set_b(1, 0, 2, 0, 0);
        #1;
        check("t6_ptr_a_gnt", 32'(a_gnt), 32'd1);
        check("t6_ptr_b_gnt", 32'(b_gnt), 32'd0);
        check("t6_ram_kept", 32'(ram_mem[9]), 32'(ref_mem[9]));
        cycle();
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); cycle();

        // Randomized traffic honouring the hold-until-granted handshake.
        pa = 0; pb = 0;
        rwe_a = 0; rwe_b = 0; raddr_a = 0; raddr_b = 0; rwd_a = 0; rwd_b = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pa && ($urandom % 3 != 0)) begin
                pa = 1; rwe_a = logic'($urandom % 2);
                raddr_a = int'($urandom % 8); rwd_a = int'($urandom % 256);
            end
            if (!pb && ($urandom % 3 != 0)) begin
                pb = 1; rwe_b = logic'($urandom % 2);
                raddr_b = int'($urandom % 8); rwd_b = int'($urandom % 256);
            end
            rst = ($urandom % 60 == 0);
            set_a(pa, rwe_a, raddr_a, rwd_a, logic'($urandom % 3 != 0));
            set_b(pb, rwe_b, raddr_b, rwd_b, logic'($urandom % 3 != 0));
            cycle();
            if (g_a) pa = 0;
            if (g_b) pb = 0;
        end
        rst = 1'b0;
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
